// File: rtl/bin_dec_scheduler_if.sv
// Handshake bundle for the bin decode scheduler: parser requests,
// bitstream byte stream and the decoded bin result.
// master = parser / bitstream source side, slave = scheduler side.
interface bin_dec_scheduler_if #(
  parameter int CTX_AW = 6
);
  // Bin decode request from the syntax parser
  logic              req_valid;
  logic              req_ready;
  logic              req_bypass;
  logic [CTX_AW-1:0] req_ctx;

  // Bitstream bytes
  logic              bs_valid;
  logic              bs_ready;
  logic [7:0]        bs_data;

  // Decoded bin result
  logic              bin_valid;
  logic              bin_out;
  logic [CTX_AW-1:0] bin_ctx;

  modport master (
    output req_valid, req_bypass, req_ctx, bs_valid, bs_data,
    input  req_ready, bs_ready, bin_valid, bin_out, bin_ctx
  );

  modport slave (
    input  req_valid, req_bypass, req_ctx, bs_valid, bs_data,
    output req_ready, bs_ready, bin_valid, bin_out, bin_ctx
  );
endinterface

// File: rtl/bin_dec_scheduler.sv
// Bin decode scheduler: sequences one bin at a time through an external
// arithmetic decoder. Context-coded bins fetch their pState from an
// on-chip context table first; bypass bins go straight to the decoder.
// A small byte FIFO feeds the decoder and stalls it when it asks for a
// byte that has not arrived yet.
//
// Optional build macro: BIN_DEC_SCHED_STATS_EN adds the saturating
// statistics outputs stat_bins and stat_stalls.
module bin_dec_scheduler #(
  parameter int CTX_AW    = 6,
  parameter int BUF_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  bin_dec_scheduler_if.slave        bus,
  input  logic                      ctx_wr_en,
  input  logic [CTX_AW-1:0]         ctx_wr_addr,
  input  logic [7:0]                ctx_wr_data,
  input  logic                      ctx_upd_en,
  input  logic [7:0]                ctx_upd_data,
  output logic                      dec_step,
  output logic                      dec_bypass,
  output logic [7:0]                dec_pstate,
  output logic [7:0]                dec_data,
  input  logic                      dec_request_byte,
  input  logic                      dec_bin
`ifdef BIN_DEC_SCHED_STATS_EN
  ,
  output logic [31:0]               stat_bins,
  output logic [31:0]               stat_stalls
`endif
);

  localparam int CTX_N = 1 << CTX_AW;
  localparam int PW    = $clog2(BUF_DEPTH);
  localparam int CW    = $clog2(BUF_DEPTH) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CTX_RD = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Control state
  logic [1:0]        state;
  logic              bypass_p0;
  logic [CTX_AW-1:0] ctx_p0;

  // Bin result registers
  logic              bin_out_r;
  logic [CTX_AW-1:0] bin_ctx_r;
  logic              last_bypass;

  // Context table
  logic [7:0]        ctx_mem [CTX_N];
  logic              upd_ok;
  logic              upd_hit_wr;
  logic [7:0]        pstate_rd;

  // Byte FIFO
  logic [7:0]        buf_mem [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;

  // ---------------------------------------------------------------
  // Handshake and decoder strobes
  // ---------------------------------------------------------------
  assign bus.req_ready = (state == IDLE);
  assign bus.bin_valid = (state == DONE);
  assign bus.bin_out   = bin_out_r;
  assign bus.bin_ctx   = bin_ctx_r;

  // The decoder only advances when it has the byte it asked for.
  assign dec_step   = (state == EXEC) && !(dec_request_byte && fifo_empty);
  assign dec_bypass = bypass_p0;

  // Request acceptance and bin sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bypass_p0 <= 1'b0;
      ctx_p0    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bypass_p0 <= bus.req_bypass;
            ctx_p0    <= bus.req_ctx;
            state     <= bus.req_bypass ? EXEC : CTX_RD;
          end
        end
        CTX_RD: state <= EXEC;
        EXEC: begin
          if (dec_step) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Context table: init writes, pState updates, CTX_RD fetch
  // ---------------------------------------------------------------
  // Updates apply only to the most recent context-coded bin; an init
  // write to the same entry in the same cycle takes priority.
  assign upd_ok     = ctx_upd_en && !last_bypass;
  assign upd_hit_wr = ctx_wr_en && (ctx_wr_addr == bin_ctx_r);

  // Read with write-through so a same-cycle write is never missed
  always_comb begin
    pstate_rd = ctx_mem[ctx_p0];
    if (upd_ok && (bin_ctx_r == ctx_p0)) begin
      pstate_rd = ctx_upd_data;
    end
    if (ctx_wr_en && (ctx_wr_addr == ctx_p0)) begin
      pstate_rd = ctx_wr_data;
    end
  end

  // Table storage is deliberately left untouched by reset
  always_ff @(posedge clk) begin
    if (upd_ok && !upd_hit_wr) begin
      ctx_mem[bin_ctx_r] <= ctx_upd_data;
    end
    if (ctx_wr_en) begin
      ctx_mem[ctx_wr_addr] <= ctx_wr_data;
    end
  end

  // pState presented to the decoder, loaded during the CTX_RD cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_pstate <= 8'h00;
    end else if (state == CTX_RD) begin
      dec_pstate <= pstate_rd;
    end
  end

  // ---------------------------------------------------------------
  // Bin result capture
  // ---------------------------------------------------------------
  // last_bypass starts set so no update can land before a context bin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_out_r   <= 1'b0;
      bin_ctx_r   <= '0;
      last_bypass <= 1'b1;
    end else if (dec_step) begin
      bin_out_r   <= dec_bin;
      bin_ctx_r   <= ctx_p0;
      last_bypass <= bypass_p0;
    end
  end

  // ---------------------------------------------------------------
  // Bitstream byte FIFO
  // ---------------------------------------------------------------
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CW'(BUF_DEPTH));
  assign bus.bs_ready = !fifo_full;
  assign push        = bus.bs_valid && !fifo_full;
  assign pop         = dec_step && dec_request_byte;
  assign dec_data    = fifo_empty ? 8'h00 : buf_mem[rd_ptr];

  // Pointers wrap naturally because BUF_DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Byte storage; contents beyond the occupancy are never observed
  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[wr_ptr] <= bus.bs_data;
    end
  end

  // ---------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------
`ifdef BIN_DEC_SCHED_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count delivered bins and decoder stall cycles, holding at max
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_bins   <= 32'd0;
      stat_stalls <= 32'd0;
    end else begin
      if (state == DONE) begin
        stat_bins <= sat_inc(stat_bins);
      end
      if ((state == EXEC) && !dec_step) begin
        stat_stalls <= sat_inc(stat_stalls);
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
